// File: rtl/vram_blit.sv
// vram_blit: VRAM block-move engine for the text-mode video core.
// Performs fill and copy (scroll) operations on the character framebuffer.
// It only issues a new word transfer in cycles where the display arbiter
// raises grant.
//
// Ports:
//   CLK, RESET_N          video fast clock, asynchronous active-low reset
//   start, op             command request (sampled in IDLE only) and opcode:
//                         0=fill, 1=copy ascending, 2=copy descending,
//                         3=treated as fill
//   src_addr, dst_addr    region bases (lowest address of each region)
//   len, fill_data        word count and fill value
//   abort                 stop after the word currently in flight
//   grant                 arbiter permits a new word transfer this cycle
//   mem_addr/re/we/wdata  VRAM access port
//   mem_rdata             read data, valid RD_LAT cycles after mem_re
//   busy, done, aborted   status: busy, one-cycle done pulse, ended-by-abort
//   remaining             words not yet written
module vram_blit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8192,
    parameter int LEN_W  = 14,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    input  logic              grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining
);

    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic                is_copy_q, is_copy_d;
    logic                desc_q, desc_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                abort_pend_q, abort_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                issue_rd;
    logic                fill_wr;
    logic                copy_wr;

    // Descending operations start at the top word of the region.
    function automatic logic [ADDR_W-1:0] top_ptr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  n);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(n) - SUM_W'(1);
        return ADDR_W'(sum % SUM_W'(DEPTH));
    endfunction

    // One-word pointer step with wrap at both ends of the address space.
    function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] ptr,
                                                   input logic              down);
        if (down) begin
            return (ptr == '0) ? ADDR_W'(DEPTH - 1) : ptr - 1'b1;
        end
        return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // New words start only under grant and never in a cycle that sees abort;
    // a copy write always completes once its read has been issued.
    assign issue_rd  = (state_q == S_RD) && grant && !abort;
    assign fill_wr   = (state_q == S_WR) && !is_copy_q && grant && !abort;
    assign copy_wr   = (state_q == S_WR) && is_copy_q;
    assign mem_re    = issue_rd;
    assign mem_we    = fill_wr || copy_wr;
    assign mem_addr  = issue_rd ? src_q : dst_q;
    assign mem_wdata = is_copy_q ? mem_rdata : fill_data_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign remaining = remaining_q;

    always_comb begin
        state_d      = state_q;
        is_copy_d    = is_copy_q;
        desc_d       = desc_q;
        src_d        = src_q;
        dst_d        = dst_q;
        remaining_d  = remaining_q;
        fill_data_d  = fill_data_q;
        wait_cnt_d   = wait_cnt_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_copy_d    = (op == 2'd1) || (op == 2'd2);
                    desc_d       = (op == 2'd2);
                    fill_data_d  = fill_data;
                    remaining_d  = len;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    src_d        = (op == 2'd2) ? top_ptr(src_addr, len) : src_addr;
                    dst_d        = (op == 2'd2) ? top_ptr(dst_addr, len) : dst_addr;
                    if (len == '0) begin
                        state_d = S_FINISH;
                    end else if ((op == 2'd1) || (op == 2'd2)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
                if (abort) begin
                    state_d   = S_FINISH;
                    aborted_d = 1'b1;
                end else if (grant) begin
                    src_d      = step_ptr(src_q, desc_q);
                    wait_cnt_d = CNT_W'(RD_LAT - 1);
                    state_d    = (RD_LAT > 1) ? S_WAIT : S_WR;
                end
            end
            S_WAIT: begin
                // Grant is irrelevant here; an abort is remembered for after the write.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == CNT_W'(1)) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (is_copy_q) begin
                    remaining_d = remaining_q - 1'b1;
                    dst_d       = step_ptr(dst_q, desc_q);
                    if ((remaining_q == LEN_W'(1)) || abort || abort_pend_q) begin
                        state_d   = S_FINISH;
                        aborted_d = abort || abort_pend_q;
                    end else begin
                        state_d = S_RD;
                    end
                end else if (abort) begin
                    state_d   = S_FINISH;
                    aborted_d = 1'b1;
                end else if (grant) begin
                    remaining_d = remaining_q - 1'b1;
                    dst_d       = step_ptr(dst_q, desc_q);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            is_copy_q    <= 1'b0;
            desc_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            fill_data_q  <= '0;
            wait_cnt_q   <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_copy_q    <= is_copy_d;
            desc_q       <= desc_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            remaining_q  <= remaining_d;
            fill_data_q  <= fill_data_d;
            wait_cnt_q   <= wait_cnt_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

endmodule

// File: tb/tb_vram_blit.sv
// tb_vram_blit: self-checking bench for vram_blit.
// A behavioural VRAM answers reads with a two-cycle latency. Expected read
// addresses and write address/data pairs are queued when each operation is
// launched; a negedge monitor pops and compares them on every strobe.
module tb_vram_blit;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8192;
    localparam int LEN_W  = 14;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_data;
    logic              abort;
    logic              grant;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  remaining;

    int total;
    int bad;
    bit grant_mode;
    int grant_phase;

    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] rd_s1;
    logic [DATA_W-1:0] rd_s2;

    logic [ADDR_W-1:0] exp_rd_q [$];
    logic [ADDR_W-1:0] exp_wa_q [$];
    logic [DATA_W-1:0] exp_wd_q [$];

    vram_blit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .grant(grant),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .done(done), .aborted(aborted), .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: read captured at the edge ending the mem_re cycle, then one
    // more register stage, giving data in the cycle RD_LAT after mem_re.
    always @(posedge clk) begin
        rd_s1 <= ram[mem_addr];
        rd_s2 <= rd_s1;
        if (mem_we) ram[mem_addr] = mem_wdata;
    end
    assign mem_rdata = rd_s2;

    function automatic logic [7:0] pattern(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input int a);
        exp_rd_q.push_back(ADDR_W'(a));
    endtask

    task automatic exp_wr(input int a, input logic [7:0] d);
        exp_wa_q.push_back(ADDR_W'(a));
        exp_wd_q.push_back(d);
    endtask

    // Grant driver: steady high, or the repeating pattern 1,0,0.
    initial begin
        grant = 1'b1;
        grant_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (grant_mode) begin
                grant = (grant_phase == 0);
                grant_phase = (grant_phase == 2) ? 0 : grant_phase + 1;
            end else begin
                grant = 1'b1;
                grant_phase = 0;
            end
        end
    end

    // Monitor: every strobe is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re || mem_we) check("strobe_excl", 32'(mem_re & mem_we), 32'd0);
            if (mem_re) begin
                check("re_under_grant", 32'(grant), 32'd1);
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    check("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
                end
            end
            if (mem_we) begin
                if (exp_wa_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 32'(mem_addr), 32'(exp_wa_q.pop_front()));
                    check("wr_data", 32'(mem_wdata), 32'(exp_wd_q.pop_front()));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] o, input logic [13:0] s,
                                  input logic [13:0] d, input logic [13:0] l,
                                  input logic [7:0] f);
        @(posedge clk);
        #1;
        op = o; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_cycles);
        bit seen;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'(busy_cycles), 32'hFFFF_FFFF);
    endtask

    task automatic check_output(input string name);
        check({name, "_rd_drain"}, 32'(exp_rd_q.size()), 32'd0);
        check({name, "_wr_drain"}, 32'(exp_wa_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc;
        int n;
        total = 0; bad = 0; grant_mode = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'd0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = pattern(i);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_strobes", 32'({mem_re, mem_we}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Fill 4 words at 0x10 with 0x20.
        for (int i = 0; i < 4; i++) exp_wr(16'h10 + i, 8'h20);
        apply_stimulus(2'd0, 14'h0, 14'h10, 14'd4, 8'h20);
        wait_done(50, bc);
        check("fill_busy_cycles", 32'(bc), 32'd5);
        check("fill_remaining", 32'(remaining), 32'd0);
        check("fill_aborted", 32'(aborted), 32'd0);
        check_output("fill");
        @(negedge clk);
        check("fill_idle_busy", 32'(busy), 32'd0);
        check("fill_idle_done", 32'(done), 32'd0);

        // Scroll up one 80-word row over 4720 words.
        for (int i = 0; i < 4720; i++) begin
            exp_rd(80 + i);
            exp_wr(i, pattern(80 + i));
        end
        apply_stimulus(2'd1, 14'd80, 14'd0, 14'd4720, 8'h00);
        wait_done(20000, bc);
        check("scroll_busy_cycles", 32'(bc), 32'd14161);
        check("scroll_ram_first", 32'(ram[0]), 32'(pattern(80)));
        check("scroll_ram_last", 32'(ram[4719]), 32'(pattern(4799)));
        check_output("scroll");

        // Descending copy whose source wraps past the top of the address space.
        ram[14'h1FFE] = 8'hA1; ram[14'h1FFF] = 8'hB2; ram[0] = 8'hC3; ram[1] = 8'hD4;
        exp_rd(14'h0001); exp_rd(14'h0000); exp_rd(14'h1FFF); exp_rd(14'h1FFE);
        exp_wr(3, 8'hD4); exp_wr(2, 8'hC3); exp_wr(1, 8'hB2); exp_wr(0, 8'hA1);
        apply_stimulus(2'd2, 14'h1FFE, 14'h0000, 14'd4, 8'h00);
        wait_done(100, bc);
        check("desc_busy_cycles", 32'(bc), 32'd13);
        check("desc_ram0", 32'(ram[0]), 32'hA1);
        check("desc_ram3", 32'(ram[3]), 32'hD4);
        check_output("desc");

        // Copy under a 1,0,0 grant pattern.
        for (int i = 0; i < 6; i++) begin
            ram[14'h300 + i] = 8'h40 + 8'(i);
            exp_rd(14'h300 + i);
            exp_wr(14'h400 + i, 8'h40 + 8'(i));
        end
        grant_mode = 1'b1;
        apply_stimulus(2'd1, 14'h300, 14'h400, 14'd6, 8'h00);
        wait_done(200, bc);
        grant_mode = 1'b0;
        check("gate_remaining", 32'(remaining), 32'd0);
        check("gate_ram_last", 32'(ram[14'h405]), 32'h45);
        check_output("gate");

        // Abort during the wait of word 3 of a 10-word copy.
        for (int i = 0; i < 10; i++) ram[14'h100 + i] = 8'h90 + 8'(i);
        for (int i = 0; i < 3; i++) begin
            exp_rd(14'h100 + i);
            exp_wr(14'h200 + i, 8'h90 + 8'(i));
        end
        apply_stimulus(2'd1, 14'h100, 14'h200, 14'd10, 8'h00);
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            @(negedge clk);
            if (mem_re) n++;
        end
        check("abort_reads_seen", 32'(n), 32'd3);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        wait_done(50, bc);
        check("abort_flag", 32'(aborted), 32'd1);
        check("abort_remaining", 32'(remaining), 32'd7);
        check_output("abort");
        @(negedge clk);
        check("abort_flag_held", 32'(aborted), 32'd1);
        check("abort_done_pulse", 32'(done), 32'd0);

        // Zero length: finish without strobes; start clears aborted.
        apply_stimulus(2'd0, 14'h0, 14'h50, 14'd0, 8'h11);
        wait_done(5, bc);
        check("len0_busy_cycles", 32'(bc), 32'd1);
        check("len0_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        check("len0_idle", 32'(busy), 32'd0);

        // A start while busy is ignored.
        for (int i = 0; i < 4; i++) exp_wr(14'h500 + i, 8'h55);
        apply_stimulus(2'd0, 14'h0, 14'h500, 14'd4, 8'h55);
        op = 2'd1; src_addr = 14'h10; dst_addr = 14'h600; len = 14'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(50, bc);
        check("busy_start_cycles", 32'(bc), 32'd4);
        repeat (3) @(negedge clk);
        check("busy_start_idle", 32'(busy), 32'd0);
        check_output("busy_start");

        // Start and abort together: start wins, abort ignored.
        for (int i = 0; i < 2; i++) exp_wr(14'h680 + i, 8'h66);
        abort = 1'b1;
        apply_stimulus(2'd0, 14'h0, 14'h680, 14'd2, 8'h66);
        abort = 1'b0;
        wait_done(50, bc);
        check("start_abort_cycles", 32'(bc), 32'd3);
        check("start_abort_flag", 32'(aborted), 32'd0);
        check_output("start_abort");

        // Reset in the middle of a fill.
        for (int i = 0; i < 8; i++) exp_wr(14'h700 + i, 8'h77);
        apply_stimulus(2'd0, 14'h0, 14'h700, 14'd8, 8'h77);
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            if (mem_we) n++;
        end
        check("rstmid_writes_seen", 32'(n), 32'd2);
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_strobes", 32'({mem_re, mem_we}), 32'd0);
        check("rstmid_remaining", 32'(remaining), 32'd0);
        exp_wa_q.delete();
        exp_wd_q.delete();
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rstmid_after_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
